// File: rtl/alu_execute.sv
// alu_execute: execute stage for ADD/SUB (single cycle) and MUL (iterative
// shift-add). Results leave through a single-entry output register with a
// valid/ready handshake. Upstream is stalled while a multiply iterates or
// while the output register is occupied and not being drained.
module alu_execute #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_control,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [REG_ADDR_W-1:0] in_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic                  zero,
   output logic                  busy
);

   // Counter must hold the value DATA_WIDTH itself.
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t                state_q, state_d;

   // Multiply datapath.
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [REG_ADDR_W-1:0] mul_dest_q, mul_dest_d;

   // Output register.
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [REG_ADDR_W-1:0] out_dest_q, out_dest_d;
   logic                  zero_q, zero_d;

   logic                  accept;
   logic                  is_mul;
   logic                  is_sub;
   logic [DATA_WIDTH-1:0] addsub_value;
   logic [DATA_WIDTH-1:0] acc_step;
   logic                  mul_last;

   // Handshake, decode and single-cycle arithmetic.
   always_comb begin
      in_ready     = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
      accept       = in_valid && in_ready;
      is_mul       = (alu_control == OP_MUL);
      // Unknown codes fall through to ADD.
      is_sub       = (alu_control == OP_SUB);
      addsub_value = is_sub ? (operand_a - operand_b) : (operand_a + operand_b);
      acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
      // The counter reaches zero at this edge: this is the final iteration.
      mul_last     = (state_q == S_MUL) && (count_q == CNT_W'(1));
   end

   // Next-state logic for the FSM, multiply datapath and output register.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      count_d     = count_q;
      mul_dest_d  = mul_dest_q;
      result_d    = result_q;
      out_dest_d  = out_dest_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;

      // A drained entry empties unless something below refills it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  mcand_d    = operand_a;
                  mplier_d   = operand_b;
                  acc_d      = '0;
                  count_d    = CNT_W'(DATA_WIDTH);
                  mul_dest_d = in_dest;
                  state_d    = S_MUL;
               end else begin
                  result_d    = addsub_value;
                  out_dest_d  = in_dest;
                  zero_d      = (addsub_value == '0);
                  out_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            // The output register was free at accept and nothing else
            // writes it during the multiply, so it is free here too.
            if (mul_last) begin
               result_d    = acc_step;
               out_dest_d  = mul_dest_q;
               zero_d      = (acc_step == '0);
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flush abandons any multiply and discards the held result; it wins
      // over a same-cycle completion. in_ready already blocks an accept.
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end
   end

   // State and datapath registers, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         mul_dest_q  <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         out_dest_q  <= '0;
         zero_q      <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         mul_dest_q  <= mul_dest_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         out_dest_q  <= out_dest_d;
         zero_q      <= zero_d;
      end
   end

   // Output drive.
   always_comb begin
      out_valid = out_valid_q;
      result    = result_q;
      out_dest  = out_dest_q;
      zero      = zero_q;
      busy      = (state_q == S_MUL);
   end

endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: directed checks of reset, ADD/SUB streaming, MUL latency,
// backpressure, flush and reset mid-multiply, unknown codes, followed by a
// randomized phase scored against a transaction-level reference model.
module tb_alu_execute;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_control;
   logic [DW-1:0] operand_a;
   logic [DW-1:0] operand_b;
   logic [AW-1:0] in_dest;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] result;
   logic [AW-1:0] out_dest;
   logic          zero;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [DW-1:0] val;
      logic [AW-1:0] dest;
   } exp_t;

   alu_execute #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .alu_control(alu_control),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .in_dest(in_dest),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .out_dest(out_dest),
      .zero(zero),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Safety net: the bench must never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle: through the rising edge to the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] ctrl, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] dest);
      in_valid    = 1'b1;
      alu_control = ctrl;
      operand_a   = a;
      operand_b   = b;
      in_dest     = dest;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Reference: what the operation should produce, from the decode rules.
   function automatic logic [DW-1:0] model_op(input logic [3:0] ctrl,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
      longint unsigned p;
      if (ctrl == 4'b0001) return a - b;
      if (ctrl == 4'b0010) begin
         p = longint'(a) * longint'(b);
         return p[DW-1:0];
      end
      return a + b;
   endfunction

   // Issue a MUL from an idle, empty stage; measure busy duration and result.
   task automatic run_mul(input string tag, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] dest,
                          input logic [DW-1:0] exp);
      int cycles;
      int bad;
      drive(4'b0010, a, b, dest);
      #1 check({tag, "_ready_at_issue"}, in_ready, 1);
      tick();
      idle();
      #1;
      cycles = 0;
      bad    = 0;
      while (busy && cycles < 100) begin
         cycles++;
         if (in_ready || out_valid) bad++;
         tick();
         #1;
      end
      check({tag, "_busy_cycles"}, cycles, DW);
      check({tag, "_stall_while_busy"}, bad, 0);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, result, exp);
      check({tag, "_dest"}, out_dest, dest);
      tick();
   endtask

   initial begin
      int bad;
      int mul_left;
      exp_t exp_q[$];
      exp_t e;
      logic exp_ov;
      logic exp_rdy;
      int r;

      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      alu_control = '0;
      operand_a   = '0;
      operand_b   = '0;
      in_dest     = '0;
      out_ready   = 1'b1;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_zero", zero, 1);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_dest", out_dest, 0);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // ADD/SUB back-to-back stream.
      drive(4'b0000, 5, 7, 3);
      #1 check("add_ready", in_ready, 1);
      tick();
      drive(4'b0001, 3, 5, 4);
      #1 check("add_result", result, 12);
      check("add_dest", out_dest, 3);
      check("add_valid", out_valid, 1);
      check("stream_ready", in_ready, 1);
      tick();
      drive(4'b0001, 9, 9, 7);
      #1 check("sub_result", result, 32'hFFFF_FFFE);
      check("sub_dest", out_dest, 4);
      check("sub_zero_low", zero, 0);
      tick();
      idle();
      #1 check("sub_eq_result", result, 0);
      check("sub_eq_zero", zero, 1);
      check("sub_eq_dest", out_dest, 7);
      tick();
      #1 check("drained", out_valid, 0);

      // MUL latency and wraparound.
      run_mul("mul1", 32'h0001_0003, 32'h0000_0005, 9, 32'h0005_000F);
      run_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 32'h0000_0001);

      // Backpressure.
      out_ready = 1'b0;
      drive(4'b0000, 10, 20, 5);
      tick();
      drive(4'b0000, 1, 1, 6);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (result !== 30 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest !== 5) bad++;
         tick();
      end
      check("bp_stable", bad, 0);
      out_ready = 1'b1;
      #1 check("bp_release_ready", in_ready, 1);
      tick();
      idle();
      #1 check("bp_next_result", result, 2);
      check("bp_next_dest", out_dest, 6);
      tick();

      // Flush during MUL.
      drive(4'b0010, 7, 9, 2);
      tick();
      idle();
      repeat (9) tick();
      flush = 1'b1;
      #1 check("flush_ready_low", in_ready, 0);
      check("flush_busy_before", busy, 1);
      tick();
      flush = 1'b0;
      #1 check("flush_busy", busy, 0);
      check("flush_valid", out_valid, 0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) bad++;
         tick();
      end
      check("flush_no_result", bad, 0);
      drive(4'b0000, 100, 23, 1);
      tick();
      idle();
      #1 check("post_flush_add", result, 123);
      check("post_flush_valid", out_valid, 1);
      tick();

      // Reset during MUL: outputs clear without waiting for a clock edge.
      drive(4'b0010, 3, 3, 11);
      tick();
      idle();
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1 check("arst_busy", busy, 0);
      check("arst_valid", out_valid, 0);
      check("arst_result", result, 0);
      check("arst_zero", zero, 1);
      check("arst_dest", out_dest, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("arst_ready", in_ready, 1);
      @(negedge clk);

      // Unknown code executes as ADD.
      drive(4'b1111, 2, 3, 8);
      tick();
      idle();
      #1 check("unk_result", result, 5);
      check("unk_valid", out_valid, 1);
      tick();

      // Randomized phase against a transaction-level model.
      mul_left = 0;
      exp_q.delete();
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         if (r <= 3)      alu_control = 4'b0000;
         else if (r <= 6) alu_control = 4'b0001;
         else if (r == 7) alu_control = 4'b0010;
         else             alu_control = 4'($urandom);
         operand_a = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
         operand_b = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) operand_b = operand_a;
         in_dest   = AW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ov  = (exp_q.size() > 0) && (mul_left == 0);
         exp_rdy = (mul_left == 0) && (exp_q.size() == 0 || out_ready);
         check("rnd_valid", out_valid, exp_ov);
         check("rnd_ready", in_ready, exp_rdy);
         check("rnd_busy", busy, mul_left > 0);
         if (exp_ov && out_ready) begin
            e = exp_q.pop_front();
            check("rnd_result", result, e.val);
            check("rnd_dest", out_dest, e.dest);
            check("rnd_zero", zero, e.val == 0);
         end
         if (in_valid && exp_rdy) begin
            e.val  = model_op(alu_control, operand_a, operand_b);
            e.dest = in_dest;
            exp_q.push_back(e);
            mul_left = (alu_control == 4'b0010) ? DW : 0;
         end else if (mul_left > 0) begin
            mul_left--;
         end
         tick();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
